// File: rtl/decode.sv
// Instruction-decode stage: field decode, 32x32 register file with WB bypass,
// j redirect, load-use hazard detection and the ID/EX pipeline register.
module decode (
  input  logic        clk,
  input  logic        reset,
  input  logic        flush,
  input  logic [31:0] FetchData_IF,
  input  logic        RegWrite_WB,
  input  logic [4:0]  WriteReg_WB,
  input  logic [31:0] WriteData_WB,
  input  logic        MemRead_EX,
  input  logic [4:0]  WriteReg_EXq,
  output logic        AnyStall,
  output logic        Jump_IDM1,
  output logic [25:0] JumpTgt_IDM1,
  output logic        RegWrite_EX,
  output logic        MemRead_EXo,
  output logic        MemWrite_EX,
  output logic        Branch_EX,
  output logic        AluSrc_EX,
  output logic [2:0]  AluOp_EX,
  output logic [31:0] RsData_EX,
  output logic [31:0] RtData_EX,
  output logic [31:0] Imm_EX,
  output logic [4:0]  WriteReg_EX
);

  localparam logic [5:0] OP_R    = 6'h00;
  localparam logic [5:0] OP_J    = 6'h02;
  localparam logic [5:0] OP_BEQ  = 6'h04;
  localparam logic [5:0] OP_ADDI = 6'h08;
  localparam logic [5:0] OP_LW   = 6'h23;
  localparam logic [5:0] OP_SW   = 6'h2B;

  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;
  localparam logic [2:0] ALU_AND = 3'd2;
  localparam logic [2:0] ALU_OR  = 3'd3;
  localparam logic [2:0] ALU_SLT = 3'd4;

  logic [5:0] op;
  logic [4:0] rs;
  logic [4:0] rt;
  logic [4:0] rd;
  logic [5:0] funct;

  assign op    = FetchData_IF[31:26];
  assign rs    = FetchData_IF[25:21];
  assign rt    = FetchData_IF[20:16];
  assign rd    = FetchData_IF[15:11];
  assign funct = FetchData_IF[5:0];

  // r0 is hardwired zero, so only r1..r31 get storage.
  logic [31:0] regVal [32];
  assign regVal[0] = '0;

  genvar gi;
  generate
    for (gi = 1; gi < 32; gi++) begin : g_reg
      logic [31:0] q;
      always_ff @(posedge clk or posedge reset) begin
        if (reset)
          q <= '0;
        else if (RegWrite_WB && (WriteReg_WB == 5'(gi)))
          q <= WriteData_WB;
      end
      assign regVal[gi] = q;
    end
  endgenerate

  logic [31:0] rsData;
  logic [31:0] rtData;

  always_comb begin
    rsData = regVal[rs];
    rtData = regVal[rt];
    if (RegWrite_WB && (WriteReg_WB != 5'd0) && (WriteReg_WB == rs))
      rsData = WriteData_WB;
    if (RegWrite_WB && (WriteReg_WB != 5'd0) && (WriteReg_WB == rt))
      rtData = WriteData_WB;
  end

  logic useRt;
  assign useRt = (op == OP_R) || (op == OP_SW) || (op == OP_BEQ);

  assign AnyStall = MemRead_EX && (WriteReg_EXq != 5'd0) &&
                    ((WriteReg_EXq == rs) || ((WriteReg_EXq == rt) && useRt));

  assign Jump_IDM1    = (op == OP_J) && !flush && !AnyStall;
  assign JumpTgt_IDM1 = FetchData_IF[25:0];

  logic       regWrite;
  logic       memRead;
  logic       memWrite;
  logic       branch;
  logic       aluSrc;
  logic [2:0] aluOp;
  logic [4:0] writeReg;

  always_comb begin
    regWrite = 1'b0;
    memRead  = 1'b0;
    memWrite = 1'b0;
    branch   = 1'b0;
    aluSrc   = 1'b0;
    aluOp    = ALU_ADD;
    writeReg = rt;
    case (op)
      OP_R: begin
        writeReg = rd;
        case (funct)
          6'h20: begin regWrite = 1'b1; aluOp = ALU_ADD; end
          6'h22: begin regWrite = 1'b1; aluOp = ALU_SUB; end
          6'h24: begin regWrite = 1'b1; aluOp = ALU_AND; end
          6'h25: begin regWrite = 1'b1; aluOp = ALU_OR;  end
          6'h2A: begin regWrite = 1'b1; aluOp = ALU_SLT; end
          default: ;
        endcase
      end
      OP_LW: begin
        regWrite = 1'b1;
        memRead  = 1'b1;
        aluSrc   = 1'b1;
      end
      OP_SW: begin
        memWrite = 1'b1;
        aluSrc   = 1'b1;
      end
      OP_BEQ: begin
        branch = 1'b1;
        aluOp  = ALU_SUB;
      end
      OP_ADDI: begin
        regWrite = 1'b1;
        aluSrc   = 1'b1;
      end
      default: ;
    endcase
  end

  // Flush and stall both insert a fully zeroed bubble into EX.
  always_ff @(posedge clk or posedge reset) begin
    if (reset || flush || AnyStall) begin
      RegWrite_EX <= 1'b0;
      MemRead_EXo <= 1'b0;
      MemWrite_EX <= 1'b0;
      Branch_EX   <= 1'b0;
      AluSrc_EX   <= 1'b0;
      AluOp_EX    <= '0;
      RsData_EX   <= '0;
      RtData_EX   <= '0;
      Imm_EX      <= '0;
      WriteReg_EX <= '0;
    end else begin
      RegWrite_EX <= regWrite;
      MemRead_EXo <= memRead;
      MemWrite_EX <= memWrite;
      Branch_EX   <= branch;
      AluSrc_EX   <= aluSrc;
      AluOp_EX    <= aluOp;
      RsData_EX   <= rsData;
      RtData_EX   <= rtData;
      Imm_EX      <= {{16{FetchData_IF[15]}}, FetchData_IF[15:0]};
      WriteReg_EX <= writeReg;
    end
  end

endmodule
